riscv_pipe_stage_reg: RTL and testbench

Parametrised pipeline-stage register for the RISC-V core that carries a packed bundle of NUM_FIELDS fields, each FIELD_WIDTH bits, between adjacent stages such as fetch→decode and decode→execute. It has a valid/ready handshake and an optional two-entry skid buffer that registers the upstream ready. It also has a synchronous flush that drops in-flight instructions on branch or trap redirect. Every field resets to a parametrised value.

---
 rtl/riscv_pipe_stage_reg_if.sv | 32 +++
 rtl/riscv_pipe_stage_reg.sv | 94 +++++++++
 tb/tb_riscv_pipe_stage_reg.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_stage_reg_if.sv
// Link bundle between adjacent pipeline stages: flush, valid/ready handshake,
// packed data in both directions and an occupancy count.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 20 * `XLEN
);
  // Handshake: a bundle moves at a rising edge only when its valid and the
  // matching ready are both high; valid never waits on ready, and ready
  // (o_ready) may be computed from registered state only or, without skid,
  // from i_ready combinationally.
  logic              i_clr;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [1:0]        o_count;

  modport master (
    output i_clr, i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_clr, i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_count
  );
endinterface

// File: rtl/riscv_pipe_stage_reg.sv
// Pipeline-stage register for a packed bundle of fields, with valid/ready
// handshake, optional two-entry skid buffer and synchronous flush.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_pipe_stage_reg #(
  parameter int unsigned                NUM_FIELDS  = 20,
  parameter int unsigned                FIELD_WIDTH = `XLEN,
  parameter logic [FIELD_WIDTH-1:0]     RESET_VALUE = '0,
  parameter bit                         SKID_EN     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  riscv_pipe_stage_reg_if.slave bus
);

  localparam int unsigned W = NUM_FIELDS * FIELD_WIDTH;
  localparam logic [W-1:0] RST_BUNDLE = {NUM_FIELDS{RESET_VALUE}};

  logic         main_v_q,    main_v_d;
  logic         skid_v_q,    skid_v_d;
  logic [W-1:0] main_data_q, main_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         ready_c;
  logic         in_xfer;
  logic         out_xfer;

  always_comb begin
    // With skid, ready depends only on held state so it can be registered
    // upstream; without skid it looks through to the downstream ready.
    ready_c     = SKID_EN ? !skid_v_q : (!main_v_q || bus.i_ready);
    in_xfer     = bus.i_valid && ready_c;
    out_xfer    = main_v_q && bus.i_ready;
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;

    if (bus.i_clr) begin
      main_v_d    = 1'b0;
      main_data_d = RST_BUNDLE;
      skid_v_d    = 1'b0;
      skid_data_d = RST_BUNDLE;
    end else if (SKID_EN) begin
      if (!main_v_q || out_xfer) begin
        if (skid_v_q) begin
          // Skid entry is older than anything arriving now, so it goes first.
          main_v_d    = 1'b1;
          main_data_d = skid_data_q;
          skid_v_d    = in_xfer;
          if (in_xfer) begin
            skid_data_d = bus.i_data;
          end
        end else if (in_xfer) begin
          main_v_d    = 1'b1;
          main_data_d = bus.i_data;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_v_d    = 1'b1;
        skid_data_d = bus.i_data;
      end
    end else begin
      if (in_xfer) begin
        main_v_d    = 1'b1;
        main_data_d = bus.i_data;
      end else if (out_xfer) begin
        main_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      main_v_q    <= 1'b0;
      main_data_q <= RST_BUNDLE;
      skid_v_q    <= 1'b0;
      skid_data_q <= RST_BUNDLE;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = main_v_q;
  assign bus.o_data  = main_data_q;
  assign bus.o_count = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// Bench for riscv_pipe_stage_reg: one skid instance and one single-register
// instance, each with its own expected-output queue.
module tb_riscv_pipe_stage_reg;

  localparam int NF = 4;
  localparam int FW = 32;
  localparam int W  = NF * FW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] s_q[$];
  logic [W-1:0] f_q[$];
  logic [W-1:0] rst_exp;
  logic [W-1:0] bun_a, bun_j, bun_k;
  logic         c_taken;

  riscv_pipe_stage_reg_if #(.DATA_W(W)) s_if ();
  riscv_pipe_stage_reg_if #(.DATA_W(W)) f_if ();

  riscv_pipe_stage_reg #(
    .NUM_FIELDS(NF), .FIELD_WIDTH(FW), .RESET_VALUE(32'h13), .SKID_EN(1'b1)
  ) u_skid (
    .i_clk(clk), .i_rstn(rst_n), .bus(s_if)
  );

  riscv_pipe_stage_reg #(
    .NUM_FIELDS(NF), .FIELD_WIDTH(FW), .RESET_VALUE(32'h13), .SKID_EN(1'b0)
  ) u_flop (
    .i_clk(clk), .i_rstn(rst_n), .bus(f_if)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] f0);
    return {$urandom(), $urandom(), $urandom(), f0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboards: decide transfers at the falling edge, before the rising edge acts
  always @(negedge clk) begin
    if (!rst_n || s_if.i_clr) begin
      s_q.delete();
    end else begin
      if (s_if.o_valid && s_if.i_ready) begin
        if (s_q.size() == 0) chk("s_unexpected_out", s_q.size(), 1);
        else chk("s_data", s_if.o_data, s_q.pop_front());
      end
      if (s_if.i_valid && s_if.o_ready) s_q.push_back(s_if.i_data);
    end
  end

  always @(negedge clk) begin
    if (!rst_n || f_if.i_clr) begin
      f_q.delete();
    end else begin
      if (f_if.o_valid && f_if.i_ready) begin
        if (f_q.size() == 0) chk("f_unexpected_out", f_q.size(), 1);
        else chk("f_data", f_if.o_data, f_q.pop_front());
      end
      if (f_if.i_valid && f_if.o_ready) f_q.push_back(f_if.i_data);
    end
  end

  initial begin
    rst_exp = {NF{32'h13}};
    s_if.i_clr = 1'b0; s_if.i_valid = 1'b0; s_if.i_data = '0; s_if.i_ready = 1'b1;
    f_if.i_clr = 1'b0; f_if.i_valid = 1'b0; f_if.i_data = '0; f_if.i_ready = 1'b1;

    // reset
    repeat (2) @(posedge clk);
    #2;
    chk("s_rst_valid", s_if.o_valid, 0);
    chk("s_rst_data",  s_if.o_data, rst_exp);
    chk("s_rst_count", s_if.o_count, 0);
    chk("s_rst_ready", s_if.o_ready, 1);
    chk("f_rst_valid", f_if.o_valid, 0);
    chk("f_rst_data",  f_if.o_data, rst_exp);
    chk("f_rst_count", f_if.o_count, 0);
    chk("f_rst_ready", f_if.o_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // streaming, both modes
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        bun_a = mk(k + 1);
        s_if.i_valid = 1'b1; s_if.i_data = bun_a;
        f_if.i_valid = 1'b1; f_if.i_data = bun_a;
      end else begin
        s_if.i_valid = 1'b0;
        f_if.i_valid = 1'b0;
      end
      @(negedge clk);
      if (k == 0) begin
        chk("s_stream_lat", s_if.o_valid, 0);
        chk("f_stream_lat", f_if.o_valid, 0);
      end else begin
        chk("s_stream_v",  s_if.o_valid, 1);
        chk("s_stream_f0", s_if.o_data[31:0], k);
        chk("f_stream_v",  f_if.o_valid, 1);
        chk("f_stream_f0", f_if.o_data[31:0], k);
      end
    end
    tick();
    @(negedge clk);
    chk("s_stream_end", s_if.o_valid, 0);
    chk("f_stream_end", f_if.o_valid, 0);

    // backpressure on the skid stage: A, B taken, C held upstream
    tick();
    bun_a = mk(32'hA);
    s_if.i_ready = 1'b0; s_if.i_valid = 1'b1; s_if.i_data = bun_a;
    @(negedge clk);
    tick();
    s_if.i_data = mk(32'hB);
    @(negedge clk);
    chk("s_bp_count1", s_if.o_count, 1);
    chk("s_bp_ready1", s_if.o_ready, 1);
    chk("s_bp_dataA",  s_if.o_data, bun_a);
    tick();
    s_if.i_data = mk(32'hC);
    @(negedge clk);
    chk("s_bp_count2", s_if.o_count, 2);
    chk("s_bp_ready2", s_if.o_ready, 0);
    chk("s_bp_hold",   s_if.o_data, bun_a);
    tick();
    @(negedge clk);
    chk("s_bp_c_held", s_if.o_count, 2);
    tick();
    s_if.i_ready = 1'b1;
    @(negedge clk);
    c_taken = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c_taken) s_if.i_valid = 1'b0;
      @(negedge clk);
      if (s_if.i_valid && s_if.o_ready) c_taken = 1'b1;
    end
    chk("s_bp_c_taken", c_taken, 1);
    chk("s_bp_drained", s_q.size(), 0);

    // flush with simultaneous input and output transfers
    tick();
    s_if.i_ready = 1'b0; s_if.i_valid = 1'b1; s_if.i_data = mk(32'hD);
    f_if.i_ready = 1'b0; f_if.i_valid = 1'b1; f_if.i_data = mk(32'hD);
    @(negedge clk);
    tick();
    s_if.i_data = mk(32'hE);
    f_if.i_data = mk(32'hE);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("s_fl_pre_count", s_if.o_count, 2);
    chk("f_fl_pre_count", f_if.o_count, 1);
    tick();
    s_if.i_clr = 1'b1; s_if.i_ready = 1'b1; s_if.i_data = mk(32'hF);
    f_if.i_clr = 1'b1; f_if.i_ready = 1'b1; f_if.i_data = mk(32'hF);
    @(negedge clk);
    tick();
    s_if.i_clr = 1'b0; s_if.i_valid = 1'b0;
    f_if.i_clr = 1'b0; f_if.i_valid = 1'b0;
    @(negedge clk);
    chk("s_fl_valid", s_if.o_valid, 0);
    chk("s_fl_count", s_if.o_count, 0);
    chk("s_fl_ready", s_if.o_ready, 1);
    chk("s_fl_data",  s_if.o_data, rst_exp);
    chk("f_fl_valid", f_if.o_valid, 0);
    chk("f_fl_count", f_if.o_count, 0);
    chk("f_fl_data",  f_if.o_data, rst_exp);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("s_fl_stays_empty", s_if.o_valid, 0);
    end

    // asynchronous reset while the skid stage holds two bundles
    tick();
    s_if.i_ready = 1'b0; s_if.i_valid = 1'b1; s_if.i_data = mk(32'h6);
    @(negedge clk);
    tick();
    s_if.i_data = mk(32'h7);
    @(negedge clk);
    tick();
    s_if.i_valid = 1'b0;
    @(negedge clk);
    chk("s_ar_pre_count", s_if.o_count, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s_ar_valid", s_if.o_valid, 0);
    chk("s_ar_data",  s_if.o_data, rst_exp);
    chk("s_ar_count", s_if.o_count, 0);
    chk("s_ar_ready", s_if.o_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    s_if.i_ready = 1'b1;

    // combinational ready path without skid
    tick();
    bun_j = mk(32'h4A);
    f_if.i_ready = 1'b0; f_if.i_valid = 1'b1; f_if.i_data = bun_j;
    @(negedge clk);
    tick();
    bun_k = mk(32'h4B);
    f_if.i_data = bun_k;
    #1 chk("f_rdy_lo0", f_if.o_ready, 0);
    f_if.i_ready = 1'b1;
    #1 chk("f_rdy_hi", f_if.o_ready, 1);
    f_if.i_ready = 1'b0;
    #1 chk("f_rdy_lo1", f_if.o_ready, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("f_rdy_count", f_if.o_count, 1);
    chk("f_rdy_hold",  f_if.o_data, bun_j);
    tick();
    f_if.i_ready = 1'b1;
    @(negedge clk);
    tick();
    f_if.i_valid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("f_rdy_drained", f_q.size(), 0);

    // random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      tick();
      s_if.i_valid = 1'($urandom_range(0, 1));
      s_if.i_data  = mk(i);
      s_if.i_ready = ($urandom_range(0, 3) != 0);
      s_if.i_clr   = ($urandom_range(0, 31) == 0);
      f_if.i_valid = 1'($urandom_range(0, 1));
      f_if.i_data  = mk(i);
      f_if.i_ready = ($urandom_range(0, 2) != 0);
      f_if.i_clr   = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      chk("s_ready_vs_full", s_if.o_ready, s_if.o_count != 2);
      chk("f_count_max", f_if.o_count > 1, 0);
    end
    tick();
    s_if.i_valid = 1'b0; s_if.i_ready = 1'b1; s_if.i_clr = 1'b0;
    f_if.i_valid = 1'b0; f_if.i_ready = 1'b1; f_if.i_clr = 1'b0;
    repeat (4) begin
      tick();
      @(negedge clk);
    end
    chk("s_rand_drained", s_q.size(), 0);
    chk("f_rand_drained", f_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
